// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer: host-side transmit buffer feeding a uart_controller.
// Host bytes are queued in a circular buffer. A small request FSM presents
// one byte at a time on tx_data_o/tx_start_o and retires it on the
// controller's tx_fifo_pop strobe.
// Optional macro UART_TX_BUF_WATERMARK_EN enables a registered almost_full_o
// watermark. Without it, almost_full_o is tied low.
module uart_tx_buffer #(
  parameter int DATA_W       = 8,
  parameter int DEPTH        = 16,
  parameter int ADDR_W       = $clog2(DEPTH),
  parameter int AFULL_THRESH = DEPTH - 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              flush_i,
  input  logic              tx_en_i,
  input  logic              tx_busy_i,
  input  logic              tx_done_i,
  input  logic              tx_fifo_pop_i,
  output logic              tx_start_o,
  output logic [DATA_W-1:0] tx_data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [ADDR_W:0]   count_o,
  output logic              overflow_o,
  output logic              almost_full_o
);

  // Pointer arithmetic relies on natural wrap, so DEPTH must be a power of two.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || ADDR_W != $clog2(DEPTH) ||
      AFULL_THRESH > DEPTH) begin : g_param_check
    $error("uart_tx_buffer: DEPTH must be a power of two >= 2, ADDR_W = clog2(DEPTH), AFULL_THRESH <= DEPTH");
  end

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                ovf_q, ovf_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic                full, empty;
  logic                wr_acc, pop_acc, load;

  // Status flags come straight from the registered occupancy.
  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign full_o  = full;
  assign empty_o = empty;
  assign count_o = count_q;
  assign overflow_o = ovf_q;
  assign tx_data_o  = tx_data_q;

  // Full is judged on the pre-edge count, so a write while full is dropped
  // even if a pop retires an entry in the same cycle. Pops only count in REQ.
  assign wr_acc  = wr_en_i && !full && !flush_i;
  assign pop_acc = (state_q == ST_REQ) && tx_fifo_pop_i && !flush_i;

  // Request FSM: next state, start strobe and the data-load decision.
  always_comb begin
    state_d    = state_q;
    load       = 1'b0;
    tx_start_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!flush_i && tx_en_i && !empty && !tx_busy_i) begin
          load    = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        // The request stands regardless of tx_en_i; only pop or flush end it.
        tx_start_o = 1'b1;
        if (flush_i) begin
          state_d = ST_IDLE;
        end else if (tx_fifo_pop_i) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // The in-flight byte always completes, even across a flush.
        if (tx_done_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Buffer bookkeeping: pointers, occupancy, sticky overflow, held output byte.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    tx_data_d = tx_data_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (wr_en_i && full) begin
        ovf_d = 1'b1;
      end
      if (pop_acc) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({wr_acc, pop_acc})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
    if (load) begin
      tx_data_d = mem_q[rd_ptr_q];
    end
  end

  // Control and output registers, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= ST_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      tx_data_q <= tx_data_d;
    end
  end

  // Storage array; contents survive reset and are never cleared.
  always_ff @(posedge clk_i) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

`ifdef UART_TX_BUF_WATERMARK_EN
  localparam logic [ADDR_W:0] AFULL_CNT = (ADDR_W+1)'(AFULL_THRESH);

  logic af_q, af_d;

  // Watermark tracks the occupancy that count_q takes on this same edge.
  always_comb begin
    af_d = 1'b0;
    if (!flush_i) begin
      af_d = (count_d >= AFULL_CNT);
    end
  end

  // Watermark register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      af_q <= 1'b0;
    end else begin
      af_q <= af_d;
    end
  end

  assign almost_full_o = af_q;
`else
  assign almost_full_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_buffer.sv
// tb_uart_tx_buffer: directed bench for uart_tx_buffer (DEPTH=16, DATA_W=8).
// The bench plays the role of uart_controller by driving tx_busy, tx_done
// and tx_fifo_pop by hand.
module tb_uart_tx_buffer;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       flush;
  logic       tx_en;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_pop;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic       afull;

  int vec_cnt = 0;
  int err_cnt = 0;

  uart_tx_buffer #(
    .DATA_W(8),
    .DEPTH (16)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_n),
    .wr_en_i      (wr_en),
    .wr_data_i    (wr_data),
    .flush_i      (flush),
    .tx_en_i      (tx_en),
    .tx_busy_i    (tx_busy),
    .tx_done_i    (tx_done),
    .tx_fifo_pop_i(tx_pop),
    .tx_start_o   (tx_start),
    .tx_data_o    (tx_data),
    .full_o       (full),
    .empty_o      (empty),
    .count_o      (count),
    .overflow_o   (overflow),
    .almost_full_o(afull)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_af(input int c);
`ifdef UART_TX_BUF_WATERMARK_EN
    return (c >= 14) ? 32'd1 : 32'd0;
`else
    return (c >= 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    for (int k = 0; k < 8; k++) begin
      if (tx_start) break;
      tick();
    end
    chk({tag, "_start"}, {31'd0, tx_start}, 32'd1);
  endtask

  // One full controller transaction: request seen, pop, some busy time, done.
  task automatic serve(input string tag, input logic [7:0] exp_d, input int exp_cnt);
    wait_req(tag);
    chk({tag, "_data"}, {24'd0, tx_data}, {24'd0, exp_d});
    tx_pop = 1'b1;
    tick();
    tx_pop = 1'b0;
    chk({tag, "_cnt"}, {27'd0, count}, exp_cnt);
    chk({tag, "_af"}, {31'd0, afull}, exp_af(exp_cnt));
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_start"}, {31'd0, tx_start}, 32'd0);
    chk({tag, "_data"},  {24'd0, tx_data},  32'd0);
    chk({tag, "_cnt"},   {27'd0, count},    32'd0);
    chk({tag, "_empty"}, {31'd0, empty},    32'd1);
    chk({tag, "_full"},  {31'd0, full},     32'd0);
    chk({tag, "_ovf"},   {31'd0, overflow}, 32'd0);
    chk({tag, "_af"},    {31'd0, afull},    32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_data = 8'h00; flush = 1'b0;
    tx_en = 1'b0; tx_busy = 1'b0; tx_done = 1'b0; tx_pop = 1'b0;

    // Reset state
    repeat (2) tick();
    chk_reset_state("rst");
    rst_n = 1'b1;
    tick();
    chk("rst_rel_empty", {31'd0, empty}, 32'd1);

    // Single byte: latency, hold in REQ, pop, WAIT behaviour, back-to-back
    tx_en = 1'b1;
    write_byte(8'hA5);
    chk("a_cnt1", {27'd0, count}, 32'd1);
    chk("a_start_e0", {31'd0, tx_start}, 32'd0);
    tick();
    chk("a_start_e1", {31'd0, tx_start}, 32'd1);
    chk("a_data", {24'd0, tx_data}, 32'hA5);
    tx_en = 1'b0;
    tick();
    chk("a_req_hold", {31'd0, tx_start}, 32'd1);
    tx_en = 1'b1;
    tx_pop = 1'b1;
    tick();
    tx_pop = 1'b0;
    chk("a_pop_start", {31'd0, tx_start}, 32'd0);
    chk("a_pop_cnt", {27'd0, count}, 32'd0);
    chk("a_pop_empty", {31'd0, empty}, 32'd1);
    tx_busy = 1'b1;
    tx_pop = 1'b1;
    tick();
    tx_pop = 1'b0;
    chk("a_stray_pop", {27'd0, count}, 32'd0);
    write_byte(8'h11);
    chk("a_wait_cnt", {27'd0, count}, 32'd1);
    tick(); tick();
    chk("a_wait_hold", {31'd0, tx_start}, 32'd0);
    tx_done = 1'b1; tx_busy = 1'b0;
    tick();
    tx_done = 1'b0;
    chk("a_b2b_idle", {31'd0, tx_start}, 32'd0);
    tick();
    chk("a_b2b_start", {31'd0, tx_start}, 32'd1);
    chk("a_b2b_data", {24'd0, tx_data}, 32'h11);
    tx_pop = 1'b1; tick(); tx_pop = 1'b0;
    tick();
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    chk("a_end_empty", {31'd0, empty}, 32'd1);

    // Fill to full, overflow, write-while-full with pop, ordered drain
    tx_en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      write_byte(8'(i));
      chk($sformatf("b_fill_af%0d", i), {31'd0, afull}, exp_af(i + 1));
    end
    chk("b_full", {31'd0, full}, 32'd1);
    chk("b_cnt16", {27'd0, count}, 32'd16);
    chk("b_ovf0", {31'd0, overflow}, 32'd0);
    write_byte(8'hFF);
    chk("b_ovf1", {31'd0, overflow}, 32'd1);
    chk("b_cnt_drop", {27'd0, count}, 32'd16);
    tx_en = 1'b1;
    wait_req("b_first");
    chk("b_first_data", {24'd0, tx_data}, 32'h00);
    wr_en = 1'b1; wr_data = 8'hEE; tx_pop = 1'b1;
    tick();
    wr_en = 1'b0; tx_pop = 1'b0;
    chk("b_wrpop_cnt", {27'd0, count}, 32'd15);
    chk("b_wrpop_ovf", {31'd0, overflow}, 32'd1);
    tick();
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    for (int i = 1; i < 16; i++) begin
      serve($sformatf("b_drain%0d", i), 8'(i), 15 - i);
    end
    chk("b_drained", {31'd0, empty}, 32'd1);
    tick(); tick();
    chk("b_no_ff", {31'd0, tx_start}, 32'd0);

    // Fill to 15, simultaneous write and pop, order across pointer wrap
    tx_en = 1'b0;
    for (int i = 0; i < 15; i++) write_byte(8'h20 + 8'(i));
    chk("c_cnt15", {27'd0, count}, 32'd15);
    tx_en = 1'b1;
    wait_req("c_first");
    chk("c_first_data", {24'd0, tx_data}, 32'h20);
    wr_en = 1'b1; wr_data = 8'h2F; tx_pop = 1'b1;
    tick();
    wr_en = 1'b0; tx_pop = 1'b0;
    chk("c_simul_cnt", {27'd0, count}, 32'd15);
    write_byte(8'h30);
    chk("c_cnt16", {27'd0, count}, 32'd16);
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      serve($sformatf("c_drain%0d", i), 8'h20 + 8'(i), 16 - i);
    end

    // Flush while in REQ
    tx_en = 1'b0;
    for (int i = 0; i < 4; i++) write_byte(8'h40 + 8'(i));
    tx_en = 1'b1;
    wait_req("d_req");
    chk("d_req_data", {24'd0, tx_data}, 32'h40);
    chk("d_ovf_pre", {31'd0, overflow}, 32'd1);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("d_fl_start", {31'd0, tx_start}, 32'd0);
    chk("d_fl_cnt", {27'd0, count}, 32'd0);
    chk("d_fl_ovf", {31'd0, overflow}, 32'd0);
    chk("d_fl_empty", {31'd0, empty}, 32'd1);
    tick();
    chk("d_fl_idle", {31'd0, tx_start}, 32'd0);

    // Flush while in WAIT
    write_byte(8'h50);
    write_byte(8'h51);
    wait_req("d_w");
    chk("d_w_data", {24'd0, tx_data}, 32'h50);
    tx_pop = 1'b1; tick(); tx_pop = 1'b0;
    flush = 1'b1; tick(); flush = 1'b0;
    chk("d_wfl_cnt", {27'd0, count}, 32'd0);
    chk("d_wfl_empty", {31'd0, empty}, 32'd1);
    write_byte(8'h52);
    tick(); tick();
    chk("d_wfl_hold", {31'd0, tx_start}, 32'd0);
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    chk("d_wfl_idle", {31'd0, tx_start}, 32'd0);
    tick();
    chk("d_wfl_restart", {31'd0, tx_start}, 32'd1);
    chk("d_wfl_data", {24'd0, tx_data}, 32'h52);
    tx_pop = 1'b1; tick(); tx_pop = 1'b0;
    tick();
    tx_done = 1'b1; tick(); tx_done = 1'b0;

    // Async reset in the middle of a transmission
    tx_en = 1'b0;
    for (int i = 0; i < 5; i++) write_byte(8'h60 + 8'(i));
    tx_en = 1'b1;
    wait_req("e_req");
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_state("e_async");
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    tick();
    chk("e_rel_empty", {31'd0, empty}, 32'd1);
    write_byte(8'h3C);
    serve("e_3c", 8'h3C, 0);
    chk("e_end_empty", {31'd0, empty}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
